div_seq: RTL

- Multi-cycle sequencer for the M-extension divide ops DIV, DIVU, REM and REMU, using a restoring shift/subtract datapath.
- Sits beside the single-cycle ALU in EX. The EX stage stalls on req_ready/resp_valid while a divide is in flight.
- Detects the RISC-V special cases and returns them without iterating.

---
 rtl/div_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V special-case handling.
// Optional early-out for |a| < |b| is enabled by defining DIV_SEQ_EARLY_OUT_EN.
module div_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      op_q;
  logic [XLEN-1:0] quo, dvs, rem, result_q;
  logic [CW-1:0]   cnt;
  logic            qneg, rneg;

  logic            sgn, div0, ovf, early;
  logic [XLEN-1:0] abs_a, abs_b, q_it, r_it, fix_val;
  logic [XLEN:0]   sh, trial;

  assign sgn   = ~op_q[0];
  assign abs_a = (sgn && quo[XLEN-1]) ? -quo : quo;
  assign abs_b = (sgn && dvs[XLEN-1]) ? -dvs : dvs;
  assign div0  = (req_b == '0);
  assign ovf   = ~req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

`ifdef DIV_SEQ_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  assign req_ready   = (state == IDLE) && !flush;
  assign resp_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign resp_result = result_q;

  // UNROLL restoring steps per cycle; the remainder is always < divisor, so XLEN+1 bits hold the shift.
  always_comb begin
    r_it  = rem;
    q_it  = quo;
    sh    = '0;
    trial = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      sh    = {r_it, q_it[XLEN-1]};
      trial = sh - {1'b0, dvs};
      q_it  = {q_it[XLEN-2:0], ~trial[XLEN]};
      r_it  = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
    end
  end

  always_comb begin
    fix_val = op_q[1] ? (rneg ? -rem : rem) : (qneg ? -quo : quo);
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) state_nx = (div0 || ovf) ? DONE : PREP;
        PREP: state_nx = early ? FIX : ITER;
        ITER: if (cnt == CW'(1)) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (resp_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      result_q <= '0;
      cnt      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          quo  <= req_a;
          dvs  <= req_b;
          if (div0)     result_q <= req_op[1] ? req_a : '1;
          else if (ovf) result_q <= req_op[1] ? '0 : req_a;
        end
        PREP: begin
          qneg <= sgn & (quo[XLEN-1] ^ dvs[XLEN-1]);
          rneg <= sgn & quo[XLEN-1];
          dvs  <= abs_b;
          cnt  <= CW'(ITERS);
          if (early) begin
            rem <= abs_a;
            quo <= '0;
          end else begin
            rem <= '0;
            quo <= abs_a;
          end
        end
        ITER: begin
          rem <= r_it;
          quo <= q_it;
          cnt <= cnt - CW'(1);
        end
        FIX: result_q <= fix_val;
        default: ;
      endcase
    end
  end

endmodule
